alu_sequencer: RTL
==================

// Module: alu_sequencer
// PURPOSE
//   Sequences the shared calculator ALU (a_i/b_i/fct_i -> s_o/signal_o, 2*width result).
//   Accepts one operation command per valid/ready handshake and drives registered ALU operands and function.
//   Waits the ALU latency, then captures result and flag and presents them on a valid/ready result port.
//   Sits between the calculator front end (keypad/command decode) and the alu_alternative instance.
// PARAMETERS
//   WIDTH        8  operand width; result width is 2*WIDTH
//   ALU_LATENCY  0  ALU cycles from input change to valid output (0 = combinational ALU)
//   CNT_W        8  width of completed-operation counter
// PORTS
//   clk_i          in   1        clock, rising edge
//   rst_n_i        in   1        asynchronous active-low reset
//   cmd_valid_i    in   1        command valid
//   cmd_ready_o    out  1        command accepted when valid&ready at rising edge
//   cmd_fct_i      in   2        00 add, 01 sub, 10 mul, 11 compare (equal)
//   cmd_a_i        in   WIDTH    operand A
//   cmd_b_i        in   WIDTH    operand B
//   cmd_acc_i      in   1        use accumulator as A (only with CALC_ACC_EN)
//   alu_a_o        out  WIDTH    to ALU a_i (registered)
//   alu_b_o        out  WIDTH    to ALU b_i (registered)
//   alu_fct_o      out  2        to ALU fct_i (registered)
//   alu_s_i        in   2*WIDTH  from ALU s_o
//   alu_signal_i   in   1        from ALU signal_o
//   res_valid_o    out  1        result valid
//   res_ready_i    in   1        result consumed when valid&ready at rising edge
//   res_data_o     out  2*WIDTH  captured result
//   res_flag_o     out  1        captured signal_o (equal flag)
//   busy_o         out  1        high in any state except IDLE
//   ops_cnt_o      out  CNT_W    completed (consumed) operations, wraps 2^CNT_W-1 -> 0
// BEHAVIOUR
//   Reset (async, rst_n_i low): state IDLE; every output and internal register 0; cmd_ready_o=0 while in reset.
//   FSM: IDLE -> WAIT -> DONE -> IDLE.
//   IDLE: cmd_ready_o=1. On accept: latch A/B/fct into alu_*_o, load cnt=ALU_LATENCY, go WAIT.
//   WAIT: cmd_ready_o=0. If cnt==0: capture alu_s_i->res_data_o, alu_signal_i->res_flag_o, go DONE; else cnt--.
//   DONE: res_valid_o=1; res_data_o/res_flag_o held stable until consumed. On res_ready_i: ops_cnt++, go IDLE.
//   Latency: accept edge E0 -> res_valid_o high after edge E0+ALU_LATENCY+1.
//   Throughput: at most one op per ALU_LATENCY+3 cycles; no new command accepted before result consumed.
//   alu_*_o hold last issued values in IDLE/DONE (no ALU toggling when idle).
//   Compare op: res_data_o = ALU s_o as delivered; consumers use res_flag_o.
//   Sub: 2*WIDTH two's-complement result passed through unmodified; no saturation.
//   Reset asserted in WAIT/DONE: in-flight op discarded, no result emitted, ops_cnt_o cleared.
//   cmd_valid_i outside IDLE is ignored (not queued); inputs need not be stable when not accepted.
// CONFIGURATION
//   CALC_ACC_EN defined: acc register (WIDTH, reset 0) loaded with res_data_o[WIDTH-1:0] on each result consume.
//     Accepted cmd with cmd_acc_i=1 issues alu_a_o=acc instead of cmd_a_i (chained calculator ops).
//   CALC_ACC_EN undefined: cmd_acc_i port and acc register absent; A is always cmd_a_i.
// STRUCTURE
//   Package alu_seq_pkg: FCT_ADD/FCT_SUB/FCT_MUL/FCT_CMP 2-bit constants; state enum (IDLE, WAIT, DONE).
//   No sub-module: single FSM with latency counter; ALU instantiated by parent.
// TESTING (bench instantiates alu_alternative #(8) behind the sequencer)
//   Reset: rst_n_i low mid-sim -> all outputs 0, busy_o=0; release -> cmd_ready_o=1 next cycle.
//   Add 15+5, fct=00 -> res_data_o=16'd20, res_valid_o after 1 cycle (ALU_LATENCY=0); sub 15-5 -> 16'd10.
//   Mul 255*255, fct=10 -> res_data_o=16'hFE01; compare 15,15 -> res_flag_o=1; compare 15,14 -> res_flag_o=0.
//   Backpressure: res_ready_i low 5 cycles -> res_data_o stable, cmd_ready_o=0, extra cmd_valid_i ignored.
//   Reset in WAIT with ALU_LATENCY=3 -> no res_valid_o; next command 3+4 completes with 16'd7.
//   CALC_ACC_EN: 3*2=6 consumed, then cmd_acc_i=1, fct=00, b=4 -> res_data_o=16'd10; 256 ops -> ops_cnt_o=0.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared function codes and FSM state type for the ALU sequencer
package alu_seq_pkg;

    localparam logic [1:0] FCT_ADD = 2'b00;
    localparam logic [1:0] FCT_SUB = 2'b01;
    localparam logic [1:0] FCT_MUL = 2'b10;
    localparam logic [1:0] FCT_CMP = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } seq_state_e;

endpackage

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - one-at-a-time command/result sequencer for the shared calculator ALU
// Optional accumulator chaining is enabled by defining CALC_ACC_EN.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int ALU_LATENCY = 0,
    parameter int CNT_W       = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic [1:0]           cmd_fct_i,
    input  logic [WIDTH-1:0]     cmd_a_i,
    input  logic [WIDTH-1:0]     cmd_b_i,
`ifdef CALC_ACC_EN
    input  logic                 cmd_acc_i,
`endif
    output logic [WIDTH-1:0]     alu_a_o,
    output logic [WIDTH-1:0]     alu_b_o,
    output logic [1:0]           alu_fct_o,
    input  logic [2*WIDTH-1:0]   alu_s_i,
    input  logic                 alu_signal_i,
    output logic                 res_valid_o,
    input  logic                 res_ready_i,
    output logic [2*WIDTH-1:0]   res_data_o,
    output logic                 res_flag_o,
    output logic                 busy_o,
    output logic [CNT_W-1:0]     ops_cnt_o
);

    localparam int LAT_W = $clog2(ALU_LATENCY + 2);

    seq_state_e          state_q;
    logic [LAT_W-1:0]    cnt_q;
    logic                cmd_ready_q;
    logic [WIDTH-1:0]    alu_a_q, alu_a_d;
    logic [WIDTH-1:0]    alu_b_q;
    logic [1:0]          alu_fct_q;
    logic                res_valid_q;
    logic [2*WIDTH-1:0]  res_data_q;
    logic                res_flag_q;
    logic [CNT_W-1:0]    ops_cnt_q;
    logic                accept;

`ifdef CALC_ACC_EN
    logic [WIDTH-1:0]    acc_q;
`endif

    assign accept = (state_q == IDLE) && cmd_ready_q && cmd_valid_i;

    // Operand A source: chained accumulator value or the command operand.
    always_comb begin
        alu_a_d = cmd_a_i;
`ifdef CALC_ACC_EN
        if (cmd_acc_i) begin
            alu_a_d = acc_q;
        end
`endif
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cmd_ready_q <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_fct_q   <= FCT_ADD;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_flag_q  <= 1'b0;
            ops_cnt_q   <= '0;
`ifdef CALC_ACC_EN
            acc_q       <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        alu_a_q     <= alu_a_d;
                        alu_b_q     <= cmd_b_i;
                        alu_fct_q   <= cmd_fct_i;
                        cnt_q       <= LAT_W'(ALU_LATENCY);
                        cmd_ready_q <= 1'b0;
                        state_q     <= WAIT;
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end
                WAIT: begin
                    // Operands were registered on the accept edge; the ALU output
                    // is settled once the latency count has drained to zero.
                    if (cnt_q == '0) begin
                        res_data_q  <= alu_s_i;
                        res_flag_q  <= alu_signal_i;
                        res_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DONE: begin
                    if (res_ready_i) begin
                        res_valid_q <= 1'b0;
                        ops_cnt_q   <= ops_cnt_q + 1'b1;
                        cmd_ready_q <= 1'b1;
                        state_q     <= IDLE;
`ifdef CALC_ACC_EN
                        acc_q       <= res_data_q[WIDTH-1:0];
`endif
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    cmd_ready_q <= 1'b0;
                    res_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready_o = cmd_ready_q;
    assign alu_a_o     = alu_a_q;
    assign alu_b_o     = alu_b_q;
    assign alu_fct_o   = alu_fct_q;
    assign res_valid_o = res_valid_q;
    assign res_data_o  = res_data_q;
    assign res_flag_o  = res_flag_q;
    assign busy_o      = (state_q != IDLE);
    assign ops_cnt_o   = ops_cnt_q;

endmodule
